// File: rtl/dsram_pkg.sv
// Shared types and constants for the data SRAM controller.
// Included by the controller top and its strobe formatter.
package dsram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int SIZE_W = 2;
    localparam int STRB_W = 4;

    localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_W = 2'd2;

    // Size code 3 has no meaning of its own and behaves as a word access.
    function automatic logic [SIZE_W-1:0] norm_size(
        input logic [SIZE_W-1:0] s
    );
        return (s == 2'd3) ? SZ_W : s;
    endfunction

endpackage

// File: rtl/dsram_strb_gen.sv
// Byte-lane strobe and store-data replication for the SRAM request.
// Purely combinational; fed from the captured request registers.
module dsram_strb_gen
    import dsram_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              wr,
    input  logic [SIZE_W-1:0] size,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata_in,
    output logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] wdata_out
);

    always_comb begin
        wstrb     = '0;
        wdata_out = wdata_in;
        unique case (1'b1)
            (size == SZ_B): begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_out = {4{wdata_in[7:0]}};
            end
            (size == SZ_H): begin
                wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_out = {2{wdata_in[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
            end
        endcase
        // Loads never enable byte lanes.
        if (!wr) begin
            wstrb = '0;
        end
    end

endmodule

// File: rtl/data_sram_ctrl.sv
// Data SRAM controller: one outstanding load/store between EX and MEM.
// Request captured in IDLE, issued in ADDR, returned in DATA, held in RESP.
module data_sram_ctrl
    import dsram_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    input  logic              flush,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              rsp_ready,

    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [3:0]        data_sram_wstrb,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,

    output logic              busy
);

    state_e              state;
    state_e              state_nx;
    logic                drop;
    logic                cap_wr;
    logic [SIZE_W-1:0]   cap_size;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic [DATA_W-1:0]   rdata_q;
    logic                accept;

    assign accept = (state == ST_IDLE) && req_valid && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        req_ready     = 1'b0;
        data_sram_req = 1'b0;
        rsp_valid     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = !reset;
                if (req_valid && !flush) begin
                    state_nx = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // Request stays up through a flush; the SRAM must see it out.
                data_sram_req = 1'b1;
                if (data_sram_addr_ok) begin
                    state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_sram_data_ok) begin
                    state_nx = (drop || flush) ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (flush || rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop      <= 1'b0;
            cap_wr    <= 1'b0;
            cap_size  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                cap_wr    <= req_wr;
                cap_size  <= norm_size(req_size);
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (state == ST_DATA && data_sram_data_ok) begin
                rdata_q <= cap_wr ? '0 : data_sram_rdata;
            end
            if (state_nx == ST_IDLE) begin
                drop <= 1'b0;
            end else if (flush &&
                         (state == ST_ADDR || state == ST_DATA)) begin
                drop <= 1'b1;
            end
        end
    end

    dsram_strb_gen #(
        .DATA_W (DATA_W)
    ) u_strb_gen (
        .wr        (cap_wr),
        .size      (cap_size),
        .addr_lo   (cap_addr[1:0]),
        .wdata_in  (cap_wdata),
        .wstrb     (data_sram_wstrb),
        .wdata_out (data_sram_wdata)
    );

    assign data_sram_wr   = cap_wr;
    assign data_sram_size = cap_size;
    assign data_sram_addr = cap_addr;
    assign rsp_rdata      = rdata_q;
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Self-checking bench for data_sram_ctrl: directed scenarios plus
// randomized ops against a transaction-level expectation model.
module tb_data_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_ready = 1'b0;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok = 1'b0;
    logic        data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = 32'd0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_sram_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_wr            (req_wr),
        .req_size          (req_size),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_ready         (req_ready),
        .flush             (flush),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_ready         (rsp_ready),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .busy              (busy)
    );

    function automatic logic [1:0] m_size(input logic [1:0] sz);
        return (sz == 2'd3) ? 2'd2 : sz;
    endfunction

    function automatic logic [3:0] m_strb(input bit wr, input logic [1:0] sz,
                                          input logic [31:0] a);
        if (!wr) return 4'd0;
        if (m_size(sz) == 2'd0) return 4'(1 << (a % 4));
        if (m_size(sz) == 2'd1) return 4'(3 << (a & 32'd2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz,
                                            input logic [31:0] wd);
        if (m_size(sz) == 2'd0) return {24'd0, wd[7:0]} * 32'h01010101;
        if (m_size(sz) == 2'd1) return {16'd0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    // Present a request at a negedge in IDLE; returns at the first ADDR negedge.
    task automatic issue(input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        checks++;
        if ({req_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL issue_idle got %b want 10", {req_ready, busy});
        end
        req_valid = 1'b1; req_wr = wr; req_size = sz;
        req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_wr = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic addr_phase(input bit wr, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int dly, input bit fl);
        logic [42:0] act, exp;
        for (int i = 0; i <= dly; i++) begin
            act = {data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
                   data_sram_wstrb, req_ready, rsp_valid, busy};
            exp = {1'b1, wr, m_size(sz), a, m_strb(wr, sz, a), 3'b001};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL addr_req cyc%0d got %h want %h", i, act, exp);
            end
            if (wr) begin
                checks++;
                if (data_sram_wdata !== m_wdata(sz, wd)) begin
                    errors++;
                    $display("FAIL addr_wdata got %h want %h",
                             data_sram_wdata, m_wdata(sz, wd));
                end
            end
            data_sram_addr_ok = (i == dly);
            data_sram_data_ok = 1'($urandom);
            flush = fl && (i == 0);
            @(negedge clk);
        end
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; flush = 1'b0;
    endtask

    task automatic data_phase(input int dly, input logic [31:0] rd,
                              input bit fl);
        for (int j = 0; j <= dly; j++) begin
            checks++;
            if ({data_sram_req, rsp_valid, busy, req_ready} !== 4'b0010) begin
                errors++;
                $display("FAIL data_state got %b want 0010",
                         {data_sram_req, rsp_valid, busy, req_ready});
            end
            data_sram_addr_ok = 1'($urandom);
            data_sram_data_ok = (j == dly);
            data_sram_rdata = (j == dly) ? rd : $urandom;
            flush = fl && (j == 0);
            @(negedge clk);
        end
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; flush = 1'b0;
        data_sram_rdata = $urandom;
    endtask

    task automatic resp_phase(input logic [31:0] rd, input int dly,
                              input bit fl);
        for (int k = 0; k <= dly; k++) begin
            checks++;
            if ({rsp_valid, busy, req_ready, rsp_rdata} !== {3'b110, rd}) begin
                errors++;
                $display("FAIL resp_hold cyc%0d got %b/%h want 110/%h", k,
                         {rsp_valid, busy, req_ready}, rsp_rdata, rd);
            end
            rsp_ready = (k == dly) && !fl;
            flush = fl && (k == dly);
            data_sram_data_ok = 1'($urandom);
            data_sram_addr_ok = 1'($urandom);
            @(negedge clk);
        end
        rsp_ready = 1'b0; flush = 1'b0;
        data_sram_data_ok = 1'b0; data_sram_addr_ok = 1'b0;
    endtask

    task automatic expect_idle(input string tag);
        checks++;
        if ({busy, rsp_valid, req_ready, data_sram_req} !== 4'b0010) begin
            errors++;
            $display("FAIL %s_idle got %b want 0010", tag,
                     {busy, rsp_valid, req_ready, data_sram_req});
        end
    endtask

    task automatic test_reset;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({req_ready, busy, rsp_valid, data_sram_req, rsp_rdata} !== 36'd0)
        begin
            errors++;
            $display("FAIL reset_outputs got %b/%h want 0000/0",
                     {req_ready, busy, rsp_valid, data_sram_req}, rsp_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        expect_idle("reset_release");
    endtask

    task automatic test_load_word;
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        addr_phase(1'b0, 2'd2, 32'h100, 32'h0, 0, 1'b0);
        data_phase(0, 32'hDEADBEEF, 1'b0);
        resp_phase(32'hDEADBEEF, 0, 1'b0);
        expect_idle("load_word");
    endtask

    task automatic test_store_byte;
        checks++;
        if (m_strb(1'b1, 2'd0, 32'h103) !== 4'b1000 ||
            m_wdata(2'd0, 32'h5A) !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL store_byte_model got %b/%h want 1000/5a5a5a5a",
                     m_strb(1'b1, 2'd0, 32'h103), m_wdata(2'd0, 32'h5A));
        end
        issue(1'b1, 2'd0, 32'h103, 32'h5A);
        addr_phase(1'b1, 2'd0, 32'h103, 32'h5A, 0, 1'b0);
        data_phase(0, 32'hCAFEF00D, 1'b0);
        resp_phase(32'h0, 0, 1'b0);
        expect_idle("store_byte");
    endtask

    task automatic test_addr_stall;
        issue(1'b0, 2'd1, 32'h2002, 32'h0);
        addr_phase(1'b0, 2'd1, 32'h2002, 32'h0, 3, 1'b0);
        data_phase(1, 32'h12345678, 1'b0);
        resp_phase(32'h12345678, 0, 1'b0);
        expect_idle("addr_stall");
    endtask

    task automatic test_flush;
        issue(1'b0, 2'd2, 32'h40, 32'h0);
        addr_phase(1'b0, 2'd2, 32'h40, 32'h0, 0, 1'b0);
        data_phase(1, 32'h11112222, 1'b1);
        expect_idle("flush_data");
        issue(1'b1, 2'd1, 32'h46, 32'hABCD);
        addr_phase(1'b1, 2'd1, 32'h46, 32'hABCD, 0, 1'b0);
        data_phase(0, 32'h0, 1'b0);
        resp_phase(32'h0, 0, 1'b0);
        expect_idle("after_flush");
        issue(1'b0, 2'd0, 32'h81, 32'h0);
        addr_phase(1'b0, 2'd0, 32'h81, 32'h0, 1, 1'b1);
        data_phase(0, 32'h33334444, 1'b0);
        expect_idle("flush_addr");
        issue(1'b0, 2'd3, 32'hC0, 32'h0);
        addr_phase(1'b0, 2'd3, 32'hC0, 32'h0, 0, 1'b0);
        data_phase(0, 32'h55556666, 1'b0);
        resp_phase(32'h55556666, 0, 1'b1);
        expect_idle("flush_resp");
        req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        expect_idle("flush_idle");
    endtask

    task automatic test_rsp_hold_and_reset;
        issue(1'b0, 2'd2, 32'h200, 32'h0);
        addr_phase(1'b0, 2'd2, 32'h200, 32'h0, 0, 1'b0);
        data_phase(0, 32'h87654321, 1'b0);
        resp_phase(32'h87654321, 2, 1'b0);
        expect_idle("rsp_hold");
        issue(1'b0, 2'd2, 32'h204, 32'h0);
        addr_phase(1'b0, 2'd2, 32'h204, 32'h0, 0, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, busy, rsp_valid, data_sram_req, rsp_rdata} !== 36'd0)
        begin
            errors++;
            $display("FAIL reset_mid got %b/%h want 0000/0",
                     {req_ready, busy, rsp_valid, data_sram_req}, rsp_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_idle("reset_mid");
    endtask

    task automatic test_random;
        bit          wr;
        logic [1:0]  sz;
        logic [31:0] a, wd, rd;
        int          fm;
        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom); sz = 2'($urandom);
            a = $urandom; wd = $urandom; rd = $urandom;
            fm = $urandom_range(0, 7);
            issue(wr, sz, a, wd);
            addr_phase(wr, sz, a, wd, $urandom_range(0, 3), fm == 1);
            data_phase($urandom_range(0, 3), rd, fm == 2);
            if (fm != 1 && fm != 2) begin
                resp_phase(wr ? 32'h0 : rd, $urandom_range(0, 2), fm == 3);
            end
            expect_idle("random");
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_addr_stall();
        test_flush();
        test_rsp_hold_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_ctrl.md
DATA_SRAM_CTRL -- requirements
Module: data_sram_ctrl

Interface
REQ-001 SHALL use parameter ADDR_W, default 32, meaning data SRAM address width.
REQ-002 SHALL use parameter DATA_W, default 32, meaning data SRAM word width (fixed 32 in this release).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  EX-stage memory op present.
REQ-006 SHALL have port req_wr, req_size  in  1, 2  store flag; size 0=byte, 1=half, 2=word.
REQ-007 SHALL have port req_addr, req_wdata  in  ADDR_W, DATA_W  byte address; store data, low-aligned.
REQ-008 SHALL have port req_ready  out  1  op accepted this cycle.
REQ-009 SHALL have port flush  in  1  cancel in-flight op (exception/redirect).
REQ-010 SHALL have port rsp_valid, rsp_rdata  out  1, DATA_W  response held for MEM; raw load word (0 for stores).
REQ-011 SHALL have port rsp_ready  in  1  MEM consumes the response.
REQ-012 SHALL have ports data_sram_req, data_sram_wr, data_sram_size[1:0], data_sram_wstrb[3:0], data_sram_addr, data_sram_wdata  out  SRAM-like request channel.
REQ-013 SHALL have ports data_sram_addr_ok, data_sram_data_ok  in  1, and data_sram_rdata  in  DATA_W.
REQ-014 SHALL have port busy  out  1  state != IDLE.

Function
REQ-015 SHALL implement FSM IDLE, ADDR, DATA, RESP; one outstanding op maximum.
REQ-016 SHALL, in IDLE only, drive req_ready=1; on req_valid && !flush, capture wr/size/addr/wdata into registers, go ADDR.
REQ-017 SHALL drive data_sram_req=1 only in ADDR, all request outputs sourced from captured registers, held stable until addr_ok.
REQ-018 SHALL, in ADDR with addr_ok=1, go DATA next cycle.
REQ-019 SHALL, in DATA with data_ok=1, capture rdata (loads) and go RESP, or go IDLE if drop flag set.
REQ-020 SHALL assert rsp_valid only in RESP; on rsp_ready go IDLE; earliest new acceptance is the following cycle.
REQ-021 SHALL give latency: accept at T, data_sram_req at T+1, addr_ok at T+1 and data_ok at T+2 -> rsp_valid at T+3.
REQ-022 SHALL compute wstrb: size0 -> 4'b0001<<addr[1:0]; size1 -> 4'b0011<<{addr[1],1'b0}; size2 -> 4'b1111; loads -> 4'b0000.
REQ-023 SHALL replicate wdata: size0 -> byte x4; size1 -> half x2; size2 -> as-is.
REQ-024 SHALL, on flush in IDLE, not accept; in ADDR, keep req asserted until addr_ok (no retraction) and set drop; in DATA, set drop; in RESP, clear rsp_valid and go IDLE.
REQ-025 SHALL, when drop is set, suppress rsp_valid for that op and clear drop on return to IDLE.
REQ-026 SHALL ignore data_ok in IDLE/ADDR/RESP and addr_ok outside ADDR.
REQ-027 SHALL treat size=3 as size2.

Reset
REQ-028 SHALL, on reset, asynchronously force IDLE, drop=0, rsp_valid=0, data_sram_req=0, req_ready=0 while asserted, captured registers and rsp_rdata=0.
REQ-029 SHALL, on reset mid-op, abandon the op without waiting for data_ok; the SRAM side is reset by the same signal.

Structure
REQ-030 SHALL place state encoding, size codes (SZ_B/SZ_H/SZ_W) and request-bus width in shared package dsram_pkg.
REQ-031 SHALL contain one sub-module dsram_strb_gen (combinational wstrb/wdata formatting per REQ-022/023).

Verification
REQ-032 SHALL cover: load word addr 0x100, addr_ok and data_ok immediate, rdata 0xDEADBEEF -> rsp_valid at T+3, rsp_rdata 0xDEADBEEF.
REQ-033 SHALL cover: store byte addr 0x103 wdata 0x5A -> wstrb 4'b1000, data_sram_wdata 0x5A5A5A5A, rsp_rdata 0.
REQ-034 SHALL cover: addr_ok low 3 cycles -> req, addr, size stable all 3 cycles; req_ready 0 throughout.
REQ-035 SHALL cover: flush in DATA, then data_ok -> no rsp_valid, IDLE next cycle, next req accepted.
REQ-036 SHALL cover: rsp_ready low 2 cycles in RESP -> rsp_valid/rdata held; reset asserted in DATA -> IDLE immediately, outputs 0.
